// File: rtl/fetch_ctrl.sv
// Purpose : instruction fetch sequencer (FETCH -> ISSUE -> LOCKED) that owns the pc
//           and waits on a ROB tag when the next-pc is not yet known.
// Latency : one cycle from ic_ack to pc_valid, and one cycle from rob_modify to a
//           redirected ic_req. Backpressure: stall holds ISSUE and ignores dec_valid.
// Ports   : clk/rst (sync, active-low); ic_req/ic_addr/ic_ack icache handshake;
//           pc/pc_valid decoder view; dec_valid/dec_lock/dec_offset decoder result;
//           cdb_valid/cdb_tag/cdb_result tag broadcast; rob_modify/rob_npc redirect;
//           stall downstream hold; pc_locked registered LOCKED indicator.
// Option  : define FETCH_CTRL_PERF_EN to add perf_fetch_cnt / perf_lock_cnt.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                TAG_W    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              dec_valid,
  input  logic [TAG_W-1:0]  dec_lock,
  input  logic [ADDR_W-1:0] dec_offset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [ADDR_W-1:0] cdb_result,
  input  logic              rob_modify,
  input  logic [ADDR_W-1:0] rob_npc,
  input  logic              stall,
  output logic              pc_locked
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_lock_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [TAG_W-1:0]    r_lock;
  logic [TAG_W-1:0]    w_lock_nxt;
  logic                r_pc_locked;
  logic                w_dec_take;
  logic                w_dec_bypass;
  logic                w_lock_hit;

  // Decoder result is only taken when the stage is not stalled.
  assign w_dec_take   = (r_state == ISSUE) && dec_valid && !stall;
  // Tag resolved on the CDB in the very cycle it is reported: skip LOCKED.
  assign w_dec_bypass = cdb_valid && (dec_lock != '0) && (cdb_tag == dec_lock);
  // Tag 0 never matches, so a stray broadcast of tag 0 cannot unlock.
  assign w_lock_hit   = cdb_valid && (cdb_tag != '0) && (cdb_tag == r_lock);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_lock_nxt  = r_lock;
    if (rob_modify) begin
      // Redirect wins everywhere; a coincident ic_ack is dropped.
      w_state_nxt = FETCH;
      w_pc_nxt    = rob_npc;
      w_lock_nxt  = '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (ic_ack) w_state_nxt = ISSUE;
        end
        ISSUE: begin
          if (w_dec_take) begin
            if (dec_lock == '0) begin
              w_pc_nxt    = r_pc + dec_offset;
              w_state_nxt = FETCH;
            end else if (w_dec_bypass) begin
              w_pc_nxt    = r_pc + cdb_result;
              w_state_nxt = FETCH;
            end else begin
              w_lock_nxt  = dec_lock;
              w_state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (w_lock_hit) begin
            w_pc_nxt    = r_pc + cdb_result;
            w_lock_nxt  = '0;
            w_state_nxt = FETCH;
          end
        end
        default: begin
          w_state_nxt = FETCH;
          w_lock_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_lock      <= '0;
      r_pc_locked <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_lock      <= w_lock_nxt;
      r_pc_locked <= (w_state_nxt == LOCKED);
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_lock_cnt;

  // Only acks that actually advance to ISSUE are counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_lock_cnt  <= '0;
    end else begin
      if ((r_state == FETCH) && ic_ack && !rob_modify)
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (r_state == LOCKED)
        r_perf_lock_cnt <= r_perf_lock_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_lock_cnt  = r_perf_lock_cnt;
`endif

  // ic_req is held low while reset is applied, even though state is already FETCH.
  assign ic_req    = rst && (r_state == FETCH);
  assign ic_addr   = r_pc;
  assign pc        = r_pc;
  assign pc_valid  = (r_state == ISSUE);
  assign pc_locked = r_pc_locked;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 3;

  logic              clk;
  logic              rst;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              dec_valid;
  logic [TAG_W-1:0]  dec_lock;
  logic [ADDR_W-1:0] dec_offset;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [ADDR_W-1:0] cdb_result;
  logic              rob_modify;
  logic [ADDR_W-1:0] rob_npc;
  logic              stall;
  logic              pc_locked;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_lock_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] exp_q[$];

  fetch_ctrl #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .pc(pc), .pc_valid(pc_valid),
    .dec_valid(dec_valid), .dec_lock(dec_lock), .dec_offset(dec_offset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .rob_modify(rob_modify), .rob_npc(rob_npc),
    .stall(stall), .pc_locked(pc_locked)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_lock_cnt(perf_lock_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next fetch request and compare against the scoreboard.
  task automatic expect_fetch(input string tag);
    logic [ADDR_W-1:0] e;
    for (int i = 0; i < 20; i++) begin
      if (ic_req) begin
        if (exp_q.size() == 0) begin
          check({tag, "_sb_underflow"}, 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check(tag, 64'(ic_addr), 64'(e));
        end
        return;
      end
      tick();
    end
    check({tag, "_timeout"}, 64'(ic_req), 64'd1);
  endtask

  task automatic do_ack(input string tag);
    ic_ack = 1'b1;
    tick();
    ic_ack = 1'b0;
    check({tag, "_pc_valid"}, 64'(pc_valid), 64'd1);
  endtask

  task automatic issue(input logic [TAG_W-1:0] lk, input logic [ADDR_W-1:0] off);
    dec_valid  = 1'b1;
    dec_lock   = lk;
    dec_offset = off;
    tick();
    dec_valid  = 1'b0;
    dec_lock   = '0;
    dec_offset = '0;
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] npc, input logic with_ack);
    rob_modify = 1'b1;
    rob_npc    = npc;
    ic_ack     = with_ack;
    exp_q.push_back(npc);
    tick();
    rob_modify = 1'b0;
    ic_ack     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ic_ack = 1'b0; dec_valid = 1'b0; dec_lock = '0; dec_offset = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0; rob_modify = 1'b0;
    rob_npc = '0; stall = 1'b0;

    // Reset held: no request, everything cleared.
    tick();
    tick();
    check("rst_ic_req", 64'(ic_req), 64'd0);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_pc_valid", 64'(pc_valid), 64'd0);
    check("rst_pc_locked", 64'(pc_locked), 64'd0);

    // Release: first fetch at RESET_PC, ack arrives after 2 cycles.
    rst = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    expect_fetch("fetch_reset_pc");
    tick();
    tick();
    check("noack_ic_req", 64'(ic_req), 64'd1);
    check("noack_pc", 64'(pc), 64'h0);
    do_ack("ack0");
    check("issue_ic_req", 64'(ic_req), 64'd0);

    // Sequential advance by 4.
    exp_q.push_back(32'h4);
    issue('0, 32'h4);
    expect_fetch("fetch_plus4");

    // Reach pc=0x10, then lock on tag 3.
    do_ack("ack1");
    exp_q.push_back(32'h10);
    issue('0, 32'hC);
    expect_fetch("fetch_0x10");
    do_ack("ack2");
    issue(3'd3, 32'h0);
    check("lock3_pc_locked", 64'(pc_locked), 64'd1);
    check("lock3_ic_req", 64'(ic_req), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_result = 32'h99;
    tick();
    check("tag2_ignored_locked", 64'(pc_locked), 64'd1);
    check("tag2_ignored_pc", 64'(pc), 64'h10);
    cdb_tag = 3'd0;
    tick();
    check("tag0_ignored_locked", 64'(pc_locked), 64'd1);
    cdb_tag = 3'd3; cdb_result = 32'h20;
    exp_q.push_back(32'h30);
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    check("unlock_pc_locked", 64'(pc_locked), 64'd0);
    expect_fetch("fetch_unlock_0x30");

    // Same-cycle CDB bypass at pc=0x40.
    do_ack("ack3");
    exp_q.push_back(32'h40);
    issue('0, 32'h10);
    expect_fetch("fetch_0x40");
    do_ack("ack4");
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_result = 32'h8;
    exp_q.push_back(32'h48);
    issue(3'd5, 32'h0);
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    check("bypass_pc_locked", 64'(pc_locked), 64'd0);
    expect_fetch("fetch_bypass_0x48");

    // Redirect during LOCKED with a concurrent ack.
    do_ack("ack5");
    issue(3'd2, 32'h0);
    check("lock2_pc_locked", 64'(pc_locked), 64'd1);
    redirect(32'h100, 1'b1);
    check("redir_locked_clear", 64'(pc_locked), 64'd0);
    expect_fetch("fetch_redir_0x100");
    check("redir_pc_valid", 64'(pc_valid), 64'd0);
    // Redirect in FETCH with ack: the ack must be dropped.
    redirect(32'h200, 1'b1);
    check("redir_ack_dropped", 64'(pc_valid), 64'd0);
    expect_fetch("fetch_redir_0x200");

    // Stall holds ISSUE for 3 cycles despite dec_valid.
    do_ack("ack6");
    dec_valid = 1'b1; dec_offset = 32'h4; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 64'(pc), 64'h200);
      check("stall_pc_valid", 64'(pc_valid), 64'd1);
    end
    stall = 1'b0;
    exp_q.push_back(32'h204);
    tick();
    dec_valid = 1'b0; dec_offset = '0;
    expect_fetch("fetch_after_stall");

    // Address wrap.
    redirect(32'hFFFF_FFFC, 1'b0);
    expect_fetch("fetch_wrap_base");
    do_ack("ack7");
    exp_q.push_back(32'h4);
    issue('0, 32'h8);
    check("wrap_pc", 64'(pc), 64'h4);
    expect_fetch("fetch_wrap");

    // Reset while LOCKED.
    do_ack("ack8");
    issue(3'd6, 32'h0);
    check("lock6_pc_locked", 64'(pc_locked), 64'd1);
    rst = 1'b0;
    tick();
    check("rst_locked_pc", 64'(pc), 64'h0);
    check("rst_locked_pc_locked", 64'(pc_locked), 64'd0);
    check("rst_locked_ic_req", 64'(ic_req), 64'd0);
    rst = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    expect_fetch("fetch_after_rst");

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-002 The block SHALL have parameter TAG_W, default 3, ROB tag width; tag value 0 means "no lock".
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-004 The block SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port ic_req  out  1  icache fetch request.
REQ-007 The block SHALL have port ic_addr  out  ADDR_W  fetch address, equal to pc.
REQ-008 The block SHALL have port ic_ack  in  1  icache returns instruction this cycle.
REQ-009 The block SHALL have port pc  out  ADDR_W  address of current instruction.
REQ-010 The block SHALL have port pc_valid  out  1  instruction at pc available to decoder.
REQ-011 The block SHALL have port dec_valid  in  1  decoder consumed instruction; dec_lock/dec_offset valid.
REQ-012 The block SHALL have port dec_lock  in  TAG_W  nonzero: next pc waits on this ROB tag.
REQ-013 The block SHALL have port dec_offset  in  ADDR_W  next-pc offset when dec_lock==0.
REQ-014 The block SHALL have port cdb_valid  in  1  CDB broadcast valid.
REQ-015 The block SHALL have port cdb_tag  in  TAG_W  broadcast tag.
REQ-016 The block SHALL have port cdb_result  in  ADDR_W  resolved next-pc offset.
REQ-017 The block SHALL have port rob_modify  in  1  mispredict/redirect.
REQ-018 The block SHALL have port rob_npc  in  ADDR_W  redirect target.
REQ-019 The block SHALL have port stall  in  1  downstream stall.
REQ-020 The block SHALL have port pc_locked  out  1  high while state is LOCKED.

Function
REQ-021 The block SHALL implement states FETCH, ISSUE, LOCKED; ic_req=1 only in FETCH, pc_valid=1 only in ISSUE.
REQ-022 In FETCH, ic_ack SHALL move to ISSUE next cycle; no ack keeps FETCH with pc unchanged.
REQ-023 In ISSUE, dec_valid with stall=0 and dec_lock==0 SHALL set pc<=pc+dec_offset (mod 2^ADDR_W) and enter FETCH.
REQ-024 In ISSUE, dec_valid with stall=0 and dec_lock!=0 SHALL latch lock<=dec_lock, hold pc and enter LOCKED.
REQ-025 In ISSUE with stall=1, dec_valid SHALL be ignored and state/pc held.
REQ-026 If dec_lock!=0 and cdb_valid with cdb_tag==dec_lock in the same cycle, the block SHALL bypass LOCKED: pc<=pc+cdb_result, enter FETCH.
REQ-027 In LOCKED, cdb_valid with cdb_tag==lock SHALL set pc<=pc+cdb_result, clear lock, enter FETCH; other tags and tag 0 SHALL be ignored.
REQ-028 rob_modify SHALL have highest priority in every state: pc<=rob_npc, lock<=0, enter FETCH next cycle, regardless of stall, ic_ack, dec_valid, cdb.
REQ-029 An ic_ack coinciding with rob_modify SHALL be discarded.
REQ-030 Redirect latency SHALL be one cycle: ic_addr==rob_npc with ic_req=1 in the cycle after rob_modify.
REQ-031 pc_locked SHALL be registered and equal (state==LOCKED).

Reset
REQ-032 With rst=0 at a clock edge, the block SHALL set state FETCH, pc=RESET_PC, lock=0, pc_valid=0, pc_locked=0, and SHALL drive ic_req=0 during that cycle.
REQ-033 Reset SHALL override every other input, including mid-LOCKED and mid-FETCH; the first cycle with rst=1 SHALL assert ic_req with ic_addr=RESET_PC.

Configuration
REQ-034 With FETCH_CTRL_PERF_EN defined, the block SHALL add outputs perf_fetch_cnt and perf_lock_cnt (32 bits each): counts of accepted ic_ack and of LOCKED cycles, wrapping, cleared by reset.
REQ-035 Without FETCH_CTRL_PERF_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-036 The bench SHALL cover: reset release, ic_ack after 2 cycles, dec_valid with dec_lock=0 and dec_offset=4 -> ic_addr 0 then 4, ic_req high in FETCH.
REQ-037 The bench SHALL cover: dec_lock=3 -> pc_locked=1; cdb_tag=2 ignored; cdb_tag=3 with cdb_result=0x20 at pc=0x10 -> ic_addr 0x30, pc_locked=0.
REQ-038 The bench SHALL cover: dec_lock=5 with cdb_tag=5 and cdb_result=8 in the same cycle at pc=0x40 -> no LOCKED cycle, next ic_addr 0x48.
REQ-039 The bench SHALL cover: rob_modify with rob_npc=0x100 during LOCKED and concurrent ic_ack -> next cycle ic_addr 0x100, lock cleared, ack dropped.
REQ-040 The bench SHALL cover: stall=1 for 3 cycles in ISSUE with dec_valid=1 -> pc held; on release with offset 4 -> pc+4.
REQ-041 The bench SHALL cover: pc=0xFFFFFFFC with offset 8 -> pc=0x4 (wrap); rst=0 asserted in LOCKED -> pc=RESET_PC, pc_locked=0.
